// File: rtl/spi_slave_regbank.sv
// SPI slave with a parametrised register bank.
// All SPI pins are oversampled on the system clock through two-flop
// synchronisers. A frame carries a slave-ID phase (write or read), an
// address phase and one or more data words, with the address
// auto-incrementing between words.
module spi_slave_regbank #(
    parameter int                ID_W      = 8,
    parameter int                ADDR_W    = 8,
    parameter int                DATA_W    = 8,
    parameter int                NUM_REGS  = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 8'h10,
    parameter logic [ID_W-1:0]   SLAVE_IDW = 8'hff,
    parameter logic [ID_W-1:0]   SLAVE_IDR = 8'h00,
    parameter bit                CPOL      = 1'b0,
    parameter bit                CPHA      = 1'b0,
    localparam int               IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                         clock,
    input  logic                         n_reset,
    input  logic                         ss,
    input  logic                         sclk,
    input  logic                         mosi,
    output logic                         miso,
    output logic                         miso_oe,
    output logic [NUM_REGS*DATA_W-1:0]   reg_q,
    output logic                         wr_pulse,
    output logic [IDX_W-1:0]             wr_index,
    output logic                         busy
);

    localparam int MAX_W = (ID_W > ADDR_W) ? ((ID_W > DATA_W) ? ID_W : DATA_W)
                                           : ((ADDR_W > DATA_W) ? ADDR_W : DATA_W);
    localparam int CNT_W = $clog2(MAX_W);

    localparam logic [CNT_W-1:0]  ID_LAST    = CNT_W'(ID_W - 1);
    localparam logic [CNT_W-1:0]  ADDR_LAST  = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0]  DATA_LAST  = CNT_W'(DATA_W - 1);
    localparam logic [ADDR_W:0]   NUM_REGS_X = (ADDR_W + 1)'(NUM_REGS);
    localparam logic [ADDR_W-1:0] LAST_PTR   = ADDR_W'(NUM_REGS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ID,
        ST_ADDR,
        ST_WDATA,
        ST_RDATA,
        ST_IGNORE
    } state_t;

    // Pointer lies inside the bank.
    function automatic logic in_range(input logic [ADDR_W-1:0] p);
        return ({1'b0, p} < NUM_REGS_X);
    endfunction

    // In-range pointers wrap around the bank; out-of-range ones wrap the address space.
    function automatic logic [ADDR_W-1:0] next_ptr(input logic [ADDR_W-1:0] p);
        if (in_range(p)) begin
            return (p == LAST_PTR) ? '0 : p + ADDR_W'(1);
        end
        return p + ADDR_W'(1);
    endfunction

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic [MAX_W-2:0]       rx;
    logic [DATA_W-1:0]      tx;
    logic [ADDR_W-1:0]      ptr;
    logic                   write_txn;
    logic [DATA_W-1:0]      regs [NUM_REGS];

    logic ss_meta, ss_sync, ss_hist;
    logic sclk_meta, sclk_sync, sclk_hist;
    logic mosi_meta, mosi_sync;

    logic                   ss_fall, ss_rise;
    logic                   lead_edge, trail_edge, sample_edge, shift_edge;
    logic [MAX_W-1:0]       rx_next;
    logic [ADDR_W-1:0]      ptr_load, ptr_step;
    logic [DATA_W-1:0]      load_word, step_word;

    // Two-flop synchronisers plus one history flop for edge detection.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            ss_meta   <= 1'b0;
            ss_sync   <= 1'b0;
            ss_hist   <= 1'b0;
            sclk_meta <= 1'b0;
            sclk_sync <= 1'b0;
            sclk_hist <= 1'b0;
            mosi_meta <= 1'b0;
            mosi_sync <= 1'b0;
        end else begin
            ss_meta   <= ss;
            ss_sync   <= ss_meta;
            ss_hist   <= ss_sync;
            sclk_meta <= sclk;
            sclk_sync <= sclk_meta;
            sclk_hist <= sclk_sync;
            mosi_meta <= mosi;
            mosi_sync <= mosi_meta;
        end
    end

    // Edge decode, shift-in value and the words to present on read entry / word advance.
    // NOTE: every signal gets a default first so no latch is inferred.
    always_comb begin
        ss_fall     = ss_hist & ~ss_sync;
        ss_rise     = ~ss_hist & ss_sync;
        lead_edge   = CPOL ? (sclk_hist & ~sclk_sync) : (~sclk_hist & sclk_sync);
        trail_edge  = CPOL ? (~sclk_hist & sclk_sync) : (sclk_hist & ~sclk_sync);
        sample_edge = CPHA ? trail_edge : lead_edge;
        shift_edge  = CPHA ? lead_edge : trail_edge;
        rx_next     = {rx, mosi_sync};
        ptr_load    = rx_next[ADDR_W-1:0] - BASE_ADDR;
        ptr_step    = next_ptr(ptr);
        load_word   = '0;
        step_word   = '0;
        if (in_range(ptr_load)) begin
            load_word = regs[ptr_load[IDX_W-1:0]];
        end
        if (in_range(ptr_step)) begin
            step_word = regs[ptr_step[IDX_W-1:0]];
        end
    end

    // Frame FSM: shifts ID/address/data, commits writes and drives read data.
    // NOTE: the register bank is reset explicitly because reg_q must read zero after reset.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            rx        <= '0;
            tx        <= '0;
            ptr       <= '0;
            write_txn <= 1'b0;
            miso      <= 1'b0;
            miso_oe   <= 1'b0;
            wr_pulse  <= 1'b0;
            wr_index  <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            wr_pulse <= 1'b0;
            if (sample_edge) begin
                rx <= rx_next[MAX_W-2:0];
            end

            if (ss_rise && state != ST_IDLE) begin
                // End of frame wins over any pending bit; partial words are dropped.
                state   <= ST_IDLE;
                miso_oe <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        miso <= 1'b0;
                        if (ss_fall) begin
                            state <= ST_ID;
                            cnt   <= '0;
                        end
                    end

                    ST_ID: begin
                        if (sample_edge) begin
                            if (cnt == ID_LAST) begin
                                cnt <= '0;
                                if (rx_next[ID_W-1:0] == SLAVE_IDW) begin
                                    write_txn <= 1'b1;
                                    state     <= ST_ADDR;
                                end else if (rx_next[ID_W-1:0] == SLAVE_IDR) begin
                                    write_txn <= 1'b0;
                                    state     <= ST_ADDR;
                                end else begin
                                    state <= ST_IGNORE;
                                end
                            end else begin
                                cnt <= cnt + CNT_W'(1);
                            end
                        end
                    end

                    ST_ADDR: begin
                        if (sample_edge) begin
                            if (cnt == ADDR_LAST) begin
                                cnt <= '0;
                                ptr <= ptr_load;
                                if (write_txn) begin
                                    state <= ST_WDATA;
                                end else begin
                                    state   <= ST_RDATA;
                                    miso_oe <= 1'b1;
                                    // CPHA=0 presents the MSB before the first sample edge.
                                    if (CPHA) begin
                                        tx <= load_word;
                                    end else begin
                                        tx   <= load_word << 1;
                                        miso <= load_word[DATA_W-1];
                                    end
                                end
                            end else begin
                                cnt <= cnt + CNT_W'(1);
                            end
                        end
                    end

                    ST_WDATA: begin
                        if (sample_edge) begin
                            if (cnt == DATA_LAST) begin
                                cnt <= '0;
                                ptr <= ptr_step;
                                if (in_range(ptr)) begin
                                    regs[ptr[IDX_W-1:0]] <= rx_next[DATA_W-1:0];
                                    wr_pulse             <= 1'b1;
                                    wr_index             <= ptr[IDX_W-1:0];
                                end
                            end else begin
                                cnt <= cnt + CNT_W'(1);
                            end
                        end
                    end

                    ST_RDATA: begin
                        if (sample_edge) begin
                            if (cnt == DATA_LAST) begin
                                cnt <= '0;
                                ptr <= ptr_step;
                                if (CPHA) begin
                                    tx <= step_word;
                                end else begin
                                    tx   <= step_word << 1;
                                    miso <= step_word[DATA_W-1];
                                end
                            end else begin
                                cnt <= cnt + CNT_W'(1);
                            end
                        end else if (shift_edge && (CPHA || cnt != '0)) begin
                            // With CPHA=0 the shift edge before the first sample of a word
                            // must not disturb the already presented MSB.
                            miso <= tx[DATA_W-1];
                            tx   <= tx << 1;
                        end
                    end

                    ST_IGNORE: begin
                        miso_oe <= 1'b0;
                    end

                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Flatten the bank onto reg_q.
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign reg_q[g*DATA_W +: DATA_W] = regs[g];
    end

    assign busy = (state != ST_IDLE);

endmodule
